// File: rtl/phase_cmd_parser.sv
// Host command byte parser: turns FT245 RX FIFO bytes into phase-table writes,
// bank-swap strobes and the global output enable, dropping and counting bad commands.
module phase_cmd_parser #(
   parameter int NUM_CHANNELS   = 128,
   parameter int PHASE_WIDTH    = 8,
   parameter int TIMEOUT_CYCLES = 65535,
   localparam int AW            = $clog2(NUM_CHANNELS)
) (
   input  logic                   sys_clk,
   input  logic                   rst_n,
   input  logic [7:0]             rxfifo_data,
   input  logic                   rxfifo_empty,
   output logic                   rxfifo_rdreq,
   output logic                   phase_wr_en,
   output logic [AW-1:0]          phase_wr_addr,
   output logic [PHASE_WIDTH-1:0] phase_wr_data,
   output logic                   phase_swap,
   output logic                   out_en,
   output logic                   err_pulse,
   output logic [7:0]             err_count,
   output logic [2:0]             dbg_state_o
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   // IDLE is encoded as 0 so a reset parser reads back as idle.
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_S_ADDR = 3'd1;
   localparam logic [2:0] ST_S_DATA = 3'd2;
   localparam logic [2:0] ST_B_ADDR = 3'd3;
   localparam logic [2:0] ST_B_CNT  = 3'd4;
   localparam logic [2:0] ST_B_DATA = 3'd5;
   localparam logic [2:0] ST_E_ARG  = 3'd6;

   logic [2:0]             state_q, state_d;
   logic [AW-1:0]          addr_q, addr_d;
   logic [7:0]             cnt_q, cnt_d;
   logic                   bad_q, bad_d;
   logic [TW-1:0]          timer_q, timer_d;
   logic                   byte_valid_q;
   logic                   out_en_q, out_en_d;
   logic                   wr_en_q, wr_en_d;
   logic [AW-1:0]          wr_addr_q, wr_addr_d;
   logic [PHASE_WIDTH-1:0] wr_data_q, wr_data_d;
   logic                   swap_q, swap_d;
   logic                   err_q, err_d;
   logic [7:0]             err_cnt_q, err_cnt_d;
   logic                   addr_bad;
   logic [AW-1:0]          addr_next;

   assign rxfifo_rdreq = !rxfifo_empty;
   assign addr_bad     = (32'(rxfifo_data) >= 32'(NUM_CHANNELS));
   assign addr_next    = (addr_q == AW'(NUM_CHANNELS - 1)) ? '0 : addr_q + AW'(1);

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      cnt_d     = cnt_q;
      bad_d     = bad_q;
      timer_d   = timer_q;
      out_en_d  = out_en_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      swap_d    = 1'b0;
      err_d     = 1'b0;

      // A byte always clears the idle counter, so abort and byte never collide.
      if (state_q == ST_IDLE || byte_valid_q) begin
         timer_d = '0;
      end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
         timer_d = '0;
         state_d = ST_IDLE;
         err_d   = 1'b1;
      end else begin
         timer_d = timer_q + TW'(1);
      end

      if (byte_valid_q) begin
         case (state_q)
            ST_IDLE: begin
               case (rxfifo_data)
                  8'h01:   state_d = ST_S_ADDR;
                  8'h02:   swap_d  = 1'b1;
                  8'h03:   state_d = ST_B_ADDR;
                  8'h04:   state_d = ST_E_ARG;
                  default: err_d   = 1'b1;
               endcase
            end
            ST_S_ADDR, ST_B_ADDR: begin
               addr_d  = AW'(rxfifo_data);
               bad_d   = addr_bad;
               err_d   = addr_bad;
               state_d = (state_q == ST_S_ADDR) ? ST_S_DATA : ST_B_CNT;
            end
            ST_S_DATA: begin
               wr_en_d   = !bad_q;
               wr_addr_d = addr_q;
               wr_data_d = rxfifo_data[PHASE_WIDTH-1:0];
               state_d   = ST_IDLE;
            end
            ST_B_CNT: begin
               cnt_d   = rxfifo_data;
               state_d = (rxfifo_data == 8'd0) ? ST_IDLE : ST_B_DATA;
            end
            ST_B_DATA: begin
               // A bad start address still consumes the burst, just without writes.
               wr_en_d   = !bad_q;
               wr_addr_d = addr_q;
               wr_data_d = rxfifo_data[PHASE_WIDTH-1:0];
               addr_d    = addr_next;
               cnt_d     = cnt_q - 8'd1;
               if (cnt_q == 8'd1) state_d = ST_IDLE;
            end
            ST_E_ARG: begin
               out_en_d = rxfifo_data[0];
               state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end

      err_cnt_d = (err_d && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         addr_q       <= '0;
         cnt_q        <= '0;
         bad_q        <= 1'b0;
         timer_q      <= '0;
         byte_valid_q <= 1'b0;
         out_en_q     <= 1'b0;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         swap_q       <= 1'b0;
         err_q        <= 1'b0;
         err_cnt_q    <= '0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         cnt_q        <= cnt_d;
         bad_q        <= bad_d;
         timer_q      <= timer_d;
         byte_valid_q <= rxfifo_rdreq;
         out_en_q     <= out_en_d;
         wr_en_q      <= wr_en_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         swap_q       <= swap_d;
         err_q        <= err_d;
         err_cnt_q    <= err_cnt_d;
      end
   end

   assign phase_wr_en   = wr_en_q;
   assign phase_wr_addr = wr_addr_q;
   assign phase_wr_data = wr_data_q;
   assign phase_swap    = swap_q;
   assign out_en        = out_en_q;
   assign err_pulse     = err_q;
   assign err_count     = err_cnt_q;
   assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_phase_cmd_parser.sv
// Bench for phase_cmd_parser: legacy-mode FIFO model feeding directed and random
// commands, with a command-level reference model and latency-checked scoreboards.
module tb_phase_cmd_parser;

   localparam int NCH = 128;
   localparam int PW  = 8;
   localparam int TO  = 16;

   logic         sys_clk = 1'b0;
   logic         rst_n   = 1'b0;
   logic [7:0]   rxfifo_data = 8'h00;
   logic         rxfifo_empty;
   logic         rxfifo_rdreq;
   logic         phase_wr_en;
   logic [6:0]   phase_wr_addr;
   logic [PW-1:0] phase_wr_data;
   logic         phase_swap;
   logic         out_en;
   logic         err_pulse;
   logic [7:0]   err_count;
   logic [2:0]   dbg_state;

   phase_cmd_parser #(.NUM_CHANNELS(NCH), .PHASE_WIDTH(PW), .TIMEOUT_CYCLES(TO)) dut (
      .sys_clk(sys_clk), .rst_n(rst_n), .rxfifo_data(rxfifo_data),
      .rxfifo_empty(rxfifo_empty), .rxfifo_rdreq(rxfifo_rdreq),
      .phase_wr_en(phase_wr_en), .phase_wr_addr(phase_wr_addr),
      .phase_wr_data(phase_wr_data), .phase_swap(phase_swap), .out_en(out_en),
      .err_pulse(err_pulse), .err_count(err_count), .dbg_state_o(dbg_state)
   );

   // ---------------- clock / counters ----------------
   always #5 sys_clk = ~sys_clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------- legacy FIFO model ----------------
   logic [7:0] fifo_q[$];
   int         push_n = 0;
   int         pop_n  = 0;
   int         pop_cyc[0:8191];

   assign rxfifo_empty = (push_n == pop_n);

   always @(posedge sys_clk) begin
      cyc <= cyc + 1;
      if (rxfifo_rdreq && fifo_q.size() > 0) begin
         rxfifo_data    <= fifo_q.pop_front();
         pop_cyc[pop_n] <= cyc + 1;
         pop_n          <= pop_n + 1;
      end
   end

   task automatic push_byte(input logic [7:0] b);
      fifo_q.push_back(b);
      push_n = push_n + 1;
   endtask

   // ---------------- reference model ----------------
   logic [7:0]  cmd_q[$];
   logic [31:0] exp_wr_q[$];    // {byte index, addr, data}
   logic [15:0] exp_swap_q[$];  // byte index
   logic [15:0] exp_err_q[$];   // byte index, FFFF = no latency check
   logic [16:0] exp_en_q[$];    // {byte index, level}
   logic        model_en  = 1'b0;
   int          model_err = 0;

   task automatic exp_err(input int idx);
      exp_err_q.push_back(16'(idx));
      if (model_err < 255) model_err++;
   endtask

   task automatic model_cmd(input int base);
      int a;
      int c;
      case (cmd_q[0])
         8'h01: begin
            a = int'(cmd_q[1]);
            if (a >= NCH) exp_err(base + 1);
            else exp_wr_q.push_back({16'(base + 2), 8'(a), cmd_q[2]});
         end
         8'h02: exp_swap_q.push_back(16'(base));
         8'h03: begin
            a = int'(cmd_q[1]);
            c = int'(cmd_q[2]);
            if (a >= NCH) exp_err(base + 1);
            else for (int k = 0; k < c; k++)
               exp_wr_q.push_back({16'(base + 3 + k), 8'((a + k) % NCH), cmd_q[3 + k]});
         end
         8'h04: begin
            if (cmd_q[1][0] != model_en) begin
               model_en = cmd_q[1][0];
               exp_en_q.push_back({16'(base + 1), model_en});
            end
         end
         default: exp_err(base);
      endcase
   endtask

   task automatic send_cmd(input int gap_max);
      model_cmd(push_n);
      foreach (cmd_q[i]) begin
         if (i > 0 && gap_max > 0) repeat ($urandom_range(0, gap_max)) @(negedge sys_clk);
         push_byte(cmd_q[i]);
      end
   endtask

   // ---------------- scoreboard monitor ----------------
   logic        mon_on  = 1'b0;
   logic        prev_en = 1'b0;
   logic [31:0] mon_e;

   task automatic chk_lat(input string tag, input logic [15:0] idx);
      if (idx != 16'hFFFF) chk(tag, cyc, pop_cyc[idx] + 1);
   endtask

   always @(negedge sys_clk) begin
      if (mon_on && rst_n) begin
         if (phase_wr_en) begin
            if (exp_wr_q.size() == 0) chk("wr_unexpected", phase_wr_en, 0);
            else begin
               mon_e = exp_wr_q.pop_front();
               chk("wr_addr", phase_wr_addr, mon_e[15:8]);
               chk("wr_data", phase_wr_data, mon_e[7:0]);
               chk_lat("wr_latency", mon_e[31:16]);
            end
         end
         if (phase_swap) begin
            if (exp_swap_q.size() == 0) chk("swap_unexpected", phase_swap, 0);
            else chk_lat("swap_latency", exp_swap_q.pop_front());
         end
         if (err_pulse) begin
            if (exp_err_q.size() == 0) chk("err_unexpected", err_pulse, 0);
            else chk_lat("err_latency", exp_err_q.pop_front());
         end
         if (out_en != prev_en) begin
            if (exp_en_q.size() == 0) chk("en_unexpected", out_en, prev_en);
            else begin
               mon_e = 32'(exp_en_q.pop_front());
               chk("en_level", out_en, mon_e[0]);
               chk_lat("en_latency", mon_e[16:1]);
            end
         end
      end
      prev_en = out_en;
   end

   // Wait for the FIFO to empty, let the pipeline settle, then audit the scoreboard.
   task automatic drain();
      int n;
      n = 0;
      while (push_n != pop_n && n < 5000) begin
         @(negedge sys_clk);
         n++;
      end
      if (n >= 5000) chk("drain_timeout", push_n - pop_n, 0);
      repeat (4) @(negedge sys_clk);
      chk("pending_events", exp_wr_q.size() + exp_swap_q.size() + exp_err_q.size()
                            + exp_en_q.size(), 0);
      chk("err_count", err_count, model_err);
      chk("out_en_level", out_en, model_en);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int kind;
      int a;
      int c;
      repeat (3) @(negedge sys_clk);
      chk("rst_wr_en", phase_wr_en, 0);
      chk("rst_wr_addr", phase_wr_addr, 0);
      chk("rst_wr_data", phase_wr_data, 0);
      chk("rst_swap", phase_swap, 0);
      chk("rst_out_en", out_en, 0);
      chk("rst_err_pulse", err_pulse, 0);
      chk("rst_err_count", err_count, 0);
      chk("rst_state", dbg_state, 0);
      rst_n  = 1'b1;
      mon_on = 1'b1;
      @(negedge sys_clk);

      cmd_q = '{8'h01, 8'h05, 8'h7F}; send_cmd(0);
      drain();

      cmd_q = '{8'h02};        send_cmd(0);
      cmd_q = '{8'h04, 8'h01}; send_cmd(0);
      cmd_q = '{8'h04, 8'h00}; send_cmd(0);
      drain();

      cmd_q = '{8'h03, 8'h7E, 8'h04, 8'h0A, 8'h0B, 8'h0C, 8'h0D}; send_cmd(0);
      drain();

      cmd_q = '{8'hFF};               send_cmd(0);
      cmd_q = '{8'h01, 8'h80, 8'h33}; send_cmd(0);
      drain();
      chk("errors_count_two", err_count, 2);
      cmd_q = '{8'h01, 8'h00, 8'h11}; send_cmd(0);
      cmd_q = '{8'h03, 8'h10, 8'h00}; send_cmd(0);
      drain();

      // Abandoned SET: the parser must sit mid-command, then abort on its own.
      push_byte(8'h01);
      push_byte(8'h05);
      drain();
      chk("timeout_busy", (dbg_state != 3'd0), 1);
      exp_err(16'hFFFF);
      repeat (20) @(negedge sys_clk);
      chk("timeout_idle", dbg_state, 0);
      cmd_q = '{8'h7F}; send_cmd(0);
      drain();

      for (int n = 0; n < 60; n++) begin
         kind = $urandom_range(0, 9);
         a = ($urandom_range(0, 9) == 0) ? $urandom_range(128, 255)
           : ($urandom_range(0, 3) == 0) ? $urandom_range(120, 127) : $urandom_range(0, 127);
         cmd_q.delete();
         if (kind <= 2) cmd_q = '{8'h01, 8'(a), 8'($urandom_range(0, 255))};
         else if (kind == 3) cmd_q = '{8'h02};
         else if (kind <= 6) begin
            c = $urandom_range(0, 6);
            cmd_q = '{8'h03, 8'(a), 8'(c)};
            for (int k = 0; k < c; k++) cmd_q.push_back(8'($urandom_range(0, 255)));
         end
         else if (kind <= 8) cmd_q = '{8'h04, 8'($urandom_range(0, 255))};
         else cmd_q = '{($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom_range(5, 255))};
         send_cmd(3);
      end
      drain();

      // Reset in the middle of a burst that still expects two data bytes.
      mon_on = 1'b0;
      push_byte(8'h03); push_byte(8'h00); push_byte(8'h03); push_byte(8'hAA);
      while (push_n != pop_n) @(negedge sys_clk);
      repeat (4) @(negedge sys_clk);
      rst_n = 1'b0;
      @(negedge sys_clk);
      chk("midrst_wr_en", phase_wr_en, 0);
      chk("midrst_out_en", out_en, 0);
      chk("midrst_err_count", err_count, 0);
      chk("midrst_state", dbg_state, 0);
      model_en  = 1'b0;
      model_err = 0;
      rst_n = 1'b1;
      @(negedge sys_clk);
      mon_on = 1'b1;
      cmd_q = '{8'h01, 8'h02, 8'h44}; send_cmd(0);
      drain();

      for (int n = 0; n < 260; n++) begin
         cmd_q = '{8'hFF};
         send_cmd(0);
      end
      drain();
      chk("err_count_saturated", err_count, 255);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      n_fail++;
      $display("FAIL watchdog observed=timeout expected=finish");
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $fatal(1, "watchdog");
   end

endmodule
